// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus, redirect port and decode handshake
// shared between instruction_fetch_unit and its environment.
interface instruction_fetch_unit_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_data, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst_data, inst_pc,
        output imem_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fixed-latency instruction fetch into a prefetch FIFO with redirect flush.
// Optional IFU_ALIGN_CHECK_EN: misaligned redirects halt fetch and set fetch_err.
module instruction_fetch_unit #(
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                   CLK,
    input  logic                   resetl,
    input  logic [63:0]            startpc,
    instruction_fetch_unit_if.master bus,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   fetch_err
);
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]    LAT_C   = CW'(MEM_LAT);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [63:0]   fetch_pc;
    logic [CW-1:0] cnt;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [63:0]   pc_q   [FIFO_DEPTH];
    logic [31:0]   data_q [FIFO_DEPTH];
    logic          halt;
    logic          sample;
    logic          pop;
    logic          push;

`ifdef IFU_ALIGN_CHECK_EN
    logic halt_q;
    logic err_q;
    logic misaligned;
    assign misaligned = |bus.redirect_pc[1:0];
    assign halt       = halt_q;
    assign fetch_err  = err_q;
`else
    assign halt      = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = (fifo_count != '0);
    assign bus.inst_data  = data_q[head];
    assign bus.inst_pc    = pc_q[head];

    assign sample = (cnt == LAT_C) && !halt;
    assign pop    = bus.inst_valid && bus.inst_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push   = sample && ((fifo_count != DEPTH_C) || pop);

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            fetch_pc   <= startpc & ~64'h3;
            cnt        <= '0;
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
`ifdef IFU_ALIGN_CHECK_EN
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else if (bus.redirect_valid) begin
            cnt        <= '0;
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
            fetch_pc   <= bus.redirect_pc & ~64'h3;
`ifdef IFU_ALIGN_CHECK_EN
            halt_q     <= misaligned;
            err_q      <= misaligned;
            if (misaligned)
                fetch_pc <= bus.redirect_pc;
`endif
        end else begin
            if (push) begin
                tail     <= tail + PW'(1);
                fetch_pc <= fetch_pc + 64'd4;
                cnt      <= '0;
            end else if (cnt != LAT_C) begin
                cnt <= cnt + CW'(1);
            end
            if (pop)
                head <= head + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (resetl && !bus.redirect_valid && push) begin
            pc_q[tail]   <= fetch_pc;
            data_q[tail] <= bus.imem_data;
        end
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Drives a 64-bit fetch address into the read-only instruction memory and waits a fixed number of cycles for the read data to settle. Captures {pc, instruction} pairs into a small prefetch FIFO and presents them to decode with a valid/ready handshake. Accepts branch redirects that flush all prefetched and in-flight work.

Parameters:
MEM_LAT, 2, wait cycles after the address is stable before imem_data is sampled (0 = sample in the same cycle the address is driven)
FIFO_DEPTH, 4, prefetch entries; power of 2, >= 2
CNT_W, 3, width of fifo_count; must equal log2(FIFO_DEPTH)+1

Ports:
CLK  in  1  clock, all state updates on the rising edge
resetl  in  1  synchronous active-low reset
startpc  in  64  fetch start address, sampled while resetl=0
imem_addr  out  64  address to instruction memory; equals the fetch_pc register
imem_data  in  32  instruction word returned by memory
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  64  new fetch address
inst_valid  out  1  FIFO head holds a valid instruction
inst_data  out  32  instruction at the FIFO head
inst_pc  out  64  address of inst_data
inst_ready  in  1  decode accepts the head this cycle
fifo_count  out  CNT_W  number of occupied entries
fetch_err  out  1  misaligned-redirect error; present only with the optional feature, tied 0 otherwise

Behaviour:
- Every posedge with resetl=0:
  - fetch_pc <= startpc & ~64'h3; wait counter cnt <= 0.
  - FIFO emptied; fetch_err <= 0.
  - All in-flight work is discarded, including during a reset asserted mid-fetch.
- Outputs after reset: inst_valid=0, fifo_count=0, imem_addr=startpc&~3. inst_data and inst_pc are don't-care while inst_valid=0.
- imem_addr is a combinational copy of fetch_pc. It is held stable for at least MEM_LAT+1 consecutive cycles per fetch.
- Wait counter:
  - cnt increments each cycle while cnt < MEM_LAT.
  - When cnt == MEM_LAT, the sample condition is met.
- Push: when the sample condition is met and a slot is free, {fetch_pc, imem_data} is written at the tail, fetch_pc <= fetch_pc+4, and cnt <= 0.
  - A slot is free when fifo_count < FIFO_DEPTH, or when a pop occurs in the same cycle.
- FIFO full with the sample condition met: no push; cnt holds at MEM_LAT and fetch_pc holds. Push happens on the first cycle a slot is free, with no re-wait.
- Peak throughput is 1 instruction per MEM_LAT+1 cycles.
- Pop: when inst_valid && inst_ready, the head advances. Entries leave strictly in address order.
- Simultaneous push and pop: fifo_count is unchanged.
- inst_valid = (fifo_count != 0). inst_data and inst_pc are driven from the head entry.
- Redirect has the highest priority over push and pop. On redirect_valid=1 (with resetl=1):
  - The FIFO is emptied; push and pop are suppressed that cycle.
  - fetch_pc <= redirect_pc & ~3; cnt <= 0.
  - inst_valid is 0 on the following cycle.
  - A head entry presented with inst_ready=1 in the redirect cycle counts as not consumed.
- PC arithmetic is modulo 2^64: 0xFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Head and tail pointers wrap modulo FIFO_DEPTH.

Optional Feature:
Macro IFU_ALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 sets fetch_err=1 and enters a halt state.
  - In halt: no further pushes, the FIFO is still flushed, imem_addr holds redirect_pc unmasked, and existing pops are unaffected.
  - fetch_err clears, and fetch resumes, only on reset or on a subsequent aligned redirect.
  - startpc is always masked and never raises an error.
- Undefined: low 2 bits are always masked, and fetch_err is tied 0.

Test Plan:
1. startpc=0, MEM_LAT=2, inst_ready=1, memory returns the production program:
   - First inst_valid appears 3 cycles after reset release, with inst_pc=0x0 and inst_data=F84003E9.
   - Next entry 3 cycles later: 0x4 / F84083EA.
2. inst_ready=0 from reset:
   - fifo_count climbs to 4 with pcs 0x0, 0x4, 0x8, 0xC; then imem_addr holds 0x10 and cnt holds.
   - Assert inst_ready=1: entries drain in order, and 0x10 / F84203ED is pushed in the same cycle as the first pop.
3. fifo_count=2, then redirect_valid=1 with redirect_pc=0x20 in the same cycle as inst_ready=1:
   - Next cycle: inst_valid=0, fifo_count=0, imem_addr=0x20.
   - 3 cycles later: 0x20 / 8B0901AD. The flushed head never reappears.
4. Redirect to 0xFFFF_FFFF_FFFF_FFFC:
   - Fetch of that address, then imem_addr wraps to 0x0.
5. Assert resetl=0 for one cycle mid-wait (cnt=1) with startpc=0x34:
   - fifo_count=0, then the first output is 0x34 / D2E24680 after MEM_LAT+1 cycles.
6. With IFU_ALIGN_CHECK_EN:
   - Redirect to 0x22: fetch_err=1 and no pushes for 10 cycles.
   - Redirect to 0x24: fetch_err=0, and 0x24 / CB09018C follows.
   - Without the macro, redirect to 0x22 fetches 0x20.
